// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and defaults for the two-requester ALU arbiter
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_OP_W  = 3;
    localparam int DEF_CNT_W = 8;

    // One-hot accept vector for a selected requester id
    function automatic logic [1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - shared combinational ALU (8 operations, WIDTH-bit wrap-around)
module Alu #(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Operation select: add, sub, and, or, xor, not-a, unsigned less-than, shift-right
    always_comb begin
        y = '0;
        case (op)
            3'd0: y = a + b;
            3'd1: y = a - b;
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = ~a;
            3'd6: y = {{(WIDTH-1){1'b0}}, (a < b)};
            default: y = a >> 1;
        endcase
    end

endmodule

// File: rtl/alu_arb_rr2.sv
// rtl/alu_arb_rr2.sv - combinational two-way round-robin picker
module alu_arb_rr2
    import alu_arb_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    input  logic       idle,
    output logic [1:0] req_ready,
    output logic       sel_id
);

    // Lone requester wins; under contention the one not granted last wins
    always_comb begin
        sel_id = 1'b0;
        if (req_valid == 2'b11) begin
            sel_id = ~last_grant;
        end else if (req_valid == 2'b10) begin
            sel_id = 1'b1;
        end
        req_ready = 2'b00;
        if (idle && req_valid[sel_id]) begin
            req_ready = onehot2(sel_id);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two clients (ALU_ARB_STATS_EN enables grant counters)
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OP_W  = DEF_OP_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OP_W-1:0]  req_op0,
    input  logic [OP_W-1:0]  req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    arb_state_e       state_q, state_d;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] a_q, b_q, alu_y;
    logic             cur_id, last_grant, sel_id, hs;

    alu_arb_rr2 u_rr2 (
        .req_valid (req_valid),
        .last_grant(last_grant),
        .idle      (state_q == IDLE),
        .req_ready (req_ready),
        .sel_id    (sel_id)
    );

    Alu #(.WIDTH(WIDTH)) u_alu (
        .op(op_q),
        .a (a_q),
        .b (b_q),
        .y (alu_y)
    );

    assign hs        = |(req_valid & req_ready);
    assign rsp_valid = (state_q == RESP);

    // Next-state: accept -> execute one cycle -> hold response until taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, operand capture on accept, result capture in EXEC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cur_id     <= 1'b0;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                op_q       <= sel_id ? req_op1 : req_op0;
                a_q        <= sel_id ? req_a1  : req_a0;
                b_q        <= sel_id ? req_b1  : req_b0;
                cur_id     <= sel_id;
                last_grant <= sel_id;
            end
            if (state_q == EXEC) begin
                rsp_result <= alu_y;
                rsp_id     <= cur_id;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // Saturating per-requester accept counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (hs) begin
            if (!sel_id && (cnt0_q != {CNT_W{1'b1}})) cnt0_q <= cnt0_q + 1'b1;
            if (sel_id && (cnt1_q != {CNT_W{1'b1}}))  cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`else
    assign gnt_cnt0 = '0;
    assign gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter against a behavioural model
module tb_alu_arbiter;

    localparam int WIDTH   = 4;
    localparam int OP_W    = 3;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid, req_ready;
    logic [OP_W-1:0]  req_op0, req_op1;
    logic [WIDTH-1:0] req_a0, req_a1, req_b0, req_b1;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

    alu_arbiter #(.WIDTH(WIDTH), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .req_a0    (req_a0),
        .req_a1    (req_a1),
        .req_b0    (req_b0),
        .req_b1    (req_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_result(rsp_result),
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] res;
        int               acc;
    } exp_t;

    exp_t             q[$];
    bit               busy = 1'b0;
    int               last = 1;
    int               cnt[2] = '{0, 0};
    int               checks = 0;
    int               errors = 0;
    logic [OP_W-1:0]  op_r[2];
    logic [WIDTH-1:0] a_r[2], b_r[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] golden(input int op, input int a, input int b);
        int m;
        int r;
        m = 1 << WIDTH;
        case (op)
            0: r = (a + b) % m;
            1: r = (a - b + m) % m;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = m - 1 - a;
            6: r = (a < b) ? 1 : 0;
            default: r = a / 2;
        endcase
        return r[WIDTH-1:0];
    endfunction

    function automatic int exp_cnt(input int i);
`ifdef ALU_ARB_STATS_EN
        return cnt[i];
`else
        return 0;
`endif
    endfunction

    task automatic set_cmd(input int r, input int op, input int a, input int b);
        op_r[r] = op[OP_W-1:0];
        a_r[r]  = a[WIDTH-1:0];
        b_r[r]  = b[WIDTH-1:0];
    endtask

    // One cycle of stimulus, entered and left at a falling edge
    task automatic step(input logic [1:0] v, input logic rr, output int acc);
        logic [1:0] er;
        int         id;
        exp_t       e;
        req_valid = v;
        rsp_ready = rr;
        req_op0 = op_r[0]; req_a0 = a_r[0]; req_b0 = b_r[0];
        req_op1 = op_r[1]; req_a1 = a_r[1]; req_b1 = b_r[1];
        #1;
        er  = 2'b00;
        id  = 0;
        acc = -1;
        if (!busy && v != 2'b00) begin
            id = (v == 2'b11) ? 1 - last : (v[1] ? 1 : 0);
            er[id] = 1'b1;
        end
        chk("req_ready", {30'd0, req_ready}, {30'd0, er});
        chk("gnt_cnt0", {30'd0, gnt_cnt0}, exp_cnt(0));
        chk("gnt_cnt1", {30'd0, gnt_cnt1}, exp_cnt(1));
        if (er != 2'b00) begin
            e.id  = id;
            e.res = golden(op_r[id], a_r[id], b_r[id]);
            e.acc = cyc;
            q.push_back(e);
            busy = 1'b1;
            last = id;
            acc  = id;
            if (cnt[id] < CNT_MAX) cnt[id]++;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int d;
        for (int i = 0; i < 12 && busy; i++) step(2'b00, 1'b1, d);
        if (busy) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        q.delete();
        busy = 1'b0;
        last = 1;
        cnt  = '{0, 0};
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_rsp_result", {28'd0, rsp_result}, 32'd0);
        @(negedge clk);
    endtask

    // Response monitor: compares every presented response against the queue head
    initial begin
        bit ev;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                ev = (q.size() > 0) && (cyc >= q[0].acc + 2);
                chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
                if (rsp_valid && ev) begin
                    chk("rsp_id", {31'd0, rsp_id}, q[0].id);
                    chk("rsp_result", {28'd0, rsp_result}, {28'd0, q[0].res});
                    chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int gq[$];
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        set_cmd(0, 0, 0, 0);
        set_cmd(1, 0, 0, 0);
        req_op0 = '0; req_a0 = '0; req_b0 = '0;
        req_op1 = '0; req_a1 = '0; req_b1 = '0;
        @(negedge clk);
        do_reset(3);

        // Single requester
        set_cmd(0, 0, 4'b1010, 4'b1101);
        step(2'b01, 1'b1, acc);
        drain();

        // Contention from reset
        do_reset(2);
        set_cmd(0, 1, 5, 10);
        set_cmd(1, 1, 0, 10);
        for (int i = 0; i < 13; i++) begin
            step(2'b11, 1'b1, acc);
            if (acc >= 0) gq.push_back(acc);
        end
        for (int i = 0; i < 4; i++) chk("grant_order", gq[i], i % 2);
        drain();

        // Backpressure
        set_cmd(0, 2, 12, 10);
        set_cmd(1, 4, 9, 3);
        step(2'b01, 1'b1, acc);
        step(2'b11, 1'b1, acc);
        repeat (5) step(2'b11, 1'b0, acc);
        step(2'b11, 1'b1, acc);
        step(2'b11, 1'b1, acc);
        drain();

        // Reset during EXEC
        set_cmd(0, 0, 7, 6);
        step(2'b01, 1'b1, acc);
        do_reset(1);
        chk("midrst_result", {28'd0, rsp_result}, 32'd0);
        set_cmd(0, 3, 3, 8);
        set_cmd(1, 3, 1, 2);
        step(2'b11, 1'b1, acc);
        drain();

        // Op sweep from alternating requesters
        for (int op = 0; op < 8; op++) begin
            set_cmd(op % 2, op, 6, 3);
            step((op % 2) ? 2'b10 : 2'b01, 1'b1, acc);
            drain();
            set_cmd((op + 1) % 2, op, 15, 0);
            step(((op + 1) % 2) ? 2'b10 : 2'b01, 1'b1, acc);
            drain();
        end

        // Statistics saturation
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            set_cmd(1, i, i + 2, 9 - i);
            step(2'b10, 1'b1, acc);
            drain();
        end
`ifdef ALU_ARB_STATS_EN
        chk("stats_cnt1", {30'd0, gnt_cnt1}, 32'd3);
`else
        chk("stats_cnt1", {30'd0, gnt_cnt1}, 32'd0);
`endif
        chk("stats_cnt0", {30'd0, gnt_cnt0}, 32'd0);

        // Random traffic
        for (int r = 0; r < 2; r++) set_cmd(r, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        for (int i = 0; i < 600; i++) begin
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), acc);
            if (acc >= 0) set_cmd(acc, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        end
        drain();
        chk("queue_empty", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
